mult_nxn_seq: RTL and testbench

MULT_NXN_SEQ -- requirements
Module: mult_nxn_seq

---
 rtl/mult_nxn_seq.sv | 121 ++++++++++++
 tb/tb_mult_nxn_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mult_nxn_seq.sv
// mult_nxn_seq: sequential radix-4 Booth multiplier, one partial product per cycle; optional accumulate via MULT_SEQ_ACCUM_EN
module mult_nxn_seq #(
   parameter int WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_in_ready,
   input  logic               i_multa_ns,
   input  logic               i_multb_ns,
   input  logic [WIDTH-1:0]   i_multa,
   input  logic [WIDTH-1:0]   i_multb,
`ifdef MULT_SEQ_ACCUM_EN
   input  logic               i_acc_en,
`endif
   output logic               o_valid,
   input  logic               i_ready,
   output logic [2*WIDTH-1:0] o_product,
   output logic               o_busy
);
   localparam int NPP = WIDTH / 2 + 1;
   localparam int AW  = 2 * WIDTH + 2;
   localparam int CW  = $clog2(NPP + 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t             state_q, state_d;
   logic [AW-1:0]      mcand_q, mcand_d;
   logic [WIDTH+1:0]   mplr_q, mplr_d;
   logic               prev_q, prev_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [2:0]         trip;
   logic [AW-1:0]      pp;
   logic               sa, sb;
`ifdef MULT_SEQ_ACCUM_EN
   logic               acc_en_q, acc_en_d;
`endif
   assign sa         = i_multa_ns & i_multa[WIDTH-1];
   assign sb         = i_multb_ns & i_multb[WIDTH-1];
   assign trip       = {mplr_q[1:0], prev_q};
   assign o_in_ready = state_q == IDLE;
   assign o_busy     = state_q != IDLE;
   assign o_valid    = state_q == DONE;
   assign o_product  = prod_q;
   // Booth digit select: multiplicand is pre-shifted, so the digit only picks 0, +-A, +-2A
   always_comb begin
      pp = (trip == 3'b001 || trip == 3'b010) ? mcand_q :
           (trip == 3'b011)                   ? mcand_q << 1 :
           (trip == 3'b100)                   ? -(mcand_q << 1) :
           (trip == 3'b101 || trip == 3'b110) ? -mcand_q : '0;
   end
   // next-state and datapath: capture in IDLE, one Booth step per CALC cycle, hold in DONE
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      prev_d   = prev_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
`ifdef MULT_SEQ_ACCUM_EN
      acc_en_d = acc_en_q;
`endif
      case (state_q)
         IDLE: if (i_valid) begin
            mcand_d  = {{(AW-WIDTH){sa}}, i_multa};
            mplr_d   = {{2{sb}}, i_multb};
            prev_d   = 1'b0;
            acc_d    = '0;
            cnt_d    = '0;
`ifdef MULT_SEQ_ACCUM_EN
            acc_en_d = i_acc_en;
`endif
            state_d  = CALC;
         end
         CALC: begin
            acc_d   = acc_q + pp;
            mcand_d = mcand_q << 2;
            mplr_d  = {{2{mplr_q[WIDTH+1]}}, mplr_q[WIDTH+1:2]};
            prev_d  = mplr_q[1];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(NPP - 1)) begin
               state_d = DONE;
`ifdef MULT_SEQ_ACCUM_EN
               prod_d  = acc_en_q ? prod_q + acc_d[2*WIDTH-1:0] : acc_d[2*WIDTH-1:0];
`else
               prod_d  = acc_d[2*WIDTH-1:0];
`endif
            end
         end
         DONE: if (i_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state register with synchronous reset clearing every visible and internal value
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplr_q   <= '0;
         prev_q   <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
`ifdef MULT_SEQ_ACCUM_EN
         acc_en_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         prev_q   <= prev_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
`ifdef MULT_SEQ_ACCUM_EN
         acc_en_q <= acc_en_d;
`endif
      end
   end
endmodule

// File: tb/tb_mult_nxn_seq.sv
// tb_mult_nxn_seq: randomized self-checking bench for mult_nxn_seq against an arithmetic reference
module tb_mult_nxn_seq;
   localparam int W = 16;
   logic           clk = 1'b0;
   logic           rst, i_valid, i_multa_ns, i_multb_ns, i_ready, acc_en;
   logic [W-1:0]   a, b;
   logic           o_in_ready, o_valid, o_busy;
   logic [2*W-1:0] o_product;
   logic [2*W-1:0] exp_last, r;
   int             n_chk = 0, n_pass = 0;
   logic           seen;
   always #5 clk = ~clk;
   mult_nxn_seq #(.WIDTH(W)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_in_ready(o_in_ready),
      .i_multa_ns(i_multa_ns), .i_multb_ns(i_multb_ns), .i_multa(a), .i_multb(b),
`ifdef MULT_SEQ_ACCUM_EN
      .i_acc_en(acc_en),
`endif
      .o_valid(o_valid), .i_ready(i_ready), .o_product(o_product), .o_busy(o_busy)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   function automatic logic [2*W-1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic sa, input logic sb);
      longint x, y;
      x = sa ? longint'($signed(xa)) : longint'({48'd0, xa});
      y = sb ? longint'($signed(xb)) : longint'({48'd0, xb});
      return (2*W)'(x * y);
   endfunction
   task automatic scramble();
      i_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      i_multa_ns = 1'($urandom);
      i_multb_ns = 1'($urandom);
      acc_en = 1'($urandom);
   endtask
   task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic sa, input logic sb, input logic acc, input int hold,
                         output logic [2*W-1:0] res);
      logic [2*W-1:0] exp;
      int lat;
      logic ok;
      exp = model(xa, xb, sa, sb) + (acc ? exp_last : '0);
      @(negedge clk);
      check({tag, " in_ready"}, o_in_ready, 1);
      i_valid = 1'b1; a = xa; b = xb; i_multa_ns = sa; i_multb_ns = sb; acc_en = acc;
      @(negedge clk);
      check({tag, " busy"}, {o_busy, o_in_ready}, 2'b10);
      lat = 1;
      ok = 1'b1;
      while (!o_valid && lat < 30) begin
         ok &= (o_product === exp_last);
         scramble();
         @(negedge clk);
         lat++;
      end
      check({tag, " calc_hold"}, ok, 1);
      check({tag, " latency"}, lat, 10);
      check({tag, " product"}, o_product, exp);
      res = o_product;
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         scramble();
         @(negedge clk);
         ok &= o_valid & !o_in_ready & (o_product === exp);
      end
      check({tag, " done_hold"}, ok, 1);
      i_ready = 1'b1;
      i_valid = 1'b1;
      @(negedge clk);
      check({tag, " consumed"}, {o_valid, o_in_ready, o_busy}, 3'b010);
      check({tag, " kept"}, o_product, exp);
      i_ready = 1'b0;
      i_valid = 1'b0;
      exp_last = exp;
   endtask
   initial begin
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_multa_ns = 1'b0; i_multb_ns = 1'b0;
      acc_en = 1'b0; a = '0; b = '0; exp_last = '0;
      repeat (2) @(negedge clk);
      check("reset_state", {o_valid, o_busy, o_in_ready, o_product}, {3'b001, 32'd0});
      rst = 1'b0;
      run_op("u_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, r);
      check("u_ffff_const", r, 32'hFFFE0001);
      run_op("s8000_sq", 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 1, r);
      check("s8000_sq_const", r, 32'h40000000);
      run_op("s7fff_s8000", 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 0, r);
      check("s7fff_s8000_const", r, 32'hC0008000);
      run_op("sm1_uffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0, r);
      check("sm1_uffff_const", r, 32'hFFFF0001);
      run_op("u0_s1234", 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b0, 0, r);
      check("u0_s1234_const", r, 32'h00000000);
      run_op("hold5", 16'h1357, 16'hBEEF, 1'b0, 1'b1, 1'b0, 5, r);
      @(negedge clk);
      i_valid = 1'b1; a = 16'h0003; b = 16'h0005; i_multa_ns = 1'b0; i_multb_ns = 1'b0; acc_en = 1'b0;
      @(negedge clk);
      i_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
      @(negedge clk);
      check("abort_state", {o_valid, o_busy, o_in_ready, o_product}, {3'b001, 32'd0});
      rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0; exp_last = '0;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         seen |= o_valid;
      end
      check("abort_no_result", seen, 0);
`ifdef MULT_SEQ_ACCUM_EN
      run_op("acc_3x4", 16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 0, r);
      check("acc_3x4_const", r, 32'd12);
      run_op("acc_5x6", 16'd5, 16'd6, 1'b0, 1'b0, 1'b1, 0, r);
      check("acc_5x6_const", r, 32'd42);
`endif
      for (int k = 0; k < 20; k++) begin
`ifdef MULT_SEQ_ACCUM_EN
         run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), r);
`else
         run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 2)), r);
`endif
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
